lb2spi_master: RTL and testbench

//   SPI mode-0 master that drives the spi2lb_bridge slave from a simple command interface.

---
 rtl/lb2spi_master.sv | 157 +++++++++++++++
 tb/tb_lb2spi_master.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lb2spi_master.sv
// SPI mode-0 master producing {addr, control byte, data} frames for spi2lb_bridge.
// Optional macro LB2SPI_CS_GAP_EN stretches the inter-frame CS-high gap to CS_GAP cycles.
module lb2spi_master #(
   parameter int unsigned ADDR_W  = 8,
   parameter int unsigned DATA_W  = 8,
   parameter int unsigned STRB_W  = DATA_W / 8,
   parameter int unsigned CLK_DIV = 8,
   parameter int unsigned CS_GAP  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_wr,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
   input  logic [STRB_W-1:0] cmd_wstrb,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              busy,
   output logic              spi_sck,
   output logic              spi_cs_n,
   output logic              spi_mosi,
   input  logic              spi_miso
);

   localparam int unsigned N = ADDR_W + 8 + DATA_W;
`ifdef LB2SPI_CS_GAP_EN
   localparam int unsigned GAP_LEN = (CS_GAP > 2 * CLK_DIV) ? CS_GAP : 2 * CLK_DIV;
`else
   localparam int unsigned GAP_LEN = 2 * CLK_DIV + 0 * CS_GAP;
`endif
   localparam int unsigned CNT_W = $clog2(GAP_LEN + CLK_DIV) + 1;
   localparam int unsigned BIT_W = $clog2(N) + 1;

   typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

   state_t             state, state_nx;
   logic [CNT_W-1:0]   cnt, cnt_nx;
   logic [BIT_W-1:0]   bit_cnt, bit_cnt_nx;
   logic [N-1:0]       shreg, shreg_nx;
   logic [DATA_W-1:0]  rd_shift, rd_shift_nx;
   logic [DATA_W-1:0]  rsp_rdata_nx;
   logic               sck_nx, rsp_valid_nx;
   logic               is_rd, is_rd_nx;
   logic               miso_s1, miso_s2;
   logic [7:0]         ctrl;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         bit_cnt   <= '0;
         shreg     <= '0;
         rd_shift  <= '0;
         rsp_rdata <= '0;
         rsp_valid <= 1'b0;
         spi_sck   <= 1'b0;
         is_rd     <= 1'b0;
         miso_s1   <= 1'b0;
         miso_s2   <= 1'b0;
      end else begin
         state     <= state_nx;
         cnt       <= cnt_nx;
         bit_cnt   <= bit_cnt_nx;
         shreg     <= shreg_nx;
         rd_shift  <= rd_shift_nx;
         rsp_rdata <= rsp_rdata_nx;
         rsp_valid <= rsp_valid_nx;
         spi_sck   <= sck_nx;
         is_rd     <= is_rd_nx;
         miso_s1   <= spi_miso;
         miso_s2   <= miso_s1;
      end
   end

   always_comb begin
      state_nx     = state;
      cnt_nx       = cnt;
      bit_cnt_nx   = bit_cnt;
      shreg_nx     = shreg;
      rd_shift_nx  = rd_shift;
      rsp_rdata_nx = rsp_rdata;
      rsp_valid_nx = 1'b0;
      sck_nx       = spi_sck;
      is_rd_nx     = is_rd;
      ctrl         = '0;
      ctrl[7]      = cmd_wr;
      if (cmd_wr)
         ctrl[STRB_W-1:0] = cmd_wstrb;

      case (state)
         IDLE: begin
            if (cmd_valid) begin
               shreg_nx   = {cmd_addr, ctrl, (cmd_wr ? cmd_wdata : DATA_W'(0))};
               is_rd_nx   = ~cmd_wr;
               cnt_nx     = CNT_W'(CLK_DIV - 1);
               bit_cnt_nx = BIT_W'(N - 1);
               state_nx   = SETUP;
            end
         end
         SETUP: begin
            if (cnt == '0) begin
               sck_nx   = 1'b1;
               cnt_nx   = CNT_W'(CLK_DIV - 1);
               state_nx = SHIFT;
            end else begin
               cnt_nx = cnt - 1'b1;
            end
         end
         SHIFT: begin
            if (cnt != '0) begin
               cnt_nx = cnt - 1'b1;
            end else begin
               cnt_nx = CNT_W'(CLK_DIV - 1);
               if (spi_sck) begin
                  sck_nx   = 1'b0;
                  shreg_nx = shreg << 1;
               end else if (bit_cnt == '0) begin
                  state_nx = HOLD;
               end else begin
                  // rising edge of bit (bit_cnt-1); data-phase bits are DATA_W-1..0
                  bit_cnt_nx = bit_cnt - 1'b1;
                  sck_nx     = 1'b1;
                  if (is_rd && (bit_cnt <= BIT_W'(DATA_W)))
                     rd_shift_nx = (rd_shift << 1) | DATA_W'(miso_s2);
               end
            end
         end
         HOLD: begin
            if (cnt == '0) begin
               rsp_valid_nx = 1'b1;
               if (is_rd)
                  rsp_rdata_nx = rd_shift;
               // IDLE supplies the final CS-high cycle of the gap
               cnt_nx   = CNT_W'(GAP_LEN - 2);
               state_nx = GAP;
            end else begin
               cnt_nx = cnt - 1'b1;
            end
         end
         GAP: begin
            if (cnt == '0)
               state_nx = IDLE;
            else
               cnt_nx = cnt - 1'b1;
         end
         default: state_nx = IDLE;
      endcase
   end

   assign cmd_ready = (state == IDLE);
   assign busy      = (state != IDLE);
   assign spi_cs_n  = ~((state == SETUP) || (state == SHIFT) || (state == HOLD));
   assign spi_mosi  = ((state == SETUP) || (state == SHIFT)) & shreg[N-1];

endmodule

// File: tb/tb_lb2spi_master.sv
// Scoreboard bench for lb2spi_master with a behavioural SPI slave and frame/response monitors.
module tb_lb2spi_master;

   localparam int unsigned ADDR_W  = 8;
   localparam int unsigned DATA_W  = 8;
   localparam int unsigned STRB_W  = 1;
   localparam int unsigned CLK_DIV = 8;
   localparam int unsigned CS_GAP  = 40;
   localparam int unsigned N       = ADDR_W + 8 + DATA_W;
   localparam int unsigned LAT     = 1 + CLK_DIV * (2 * N + 2);
`ifdef LB2SPI_CS_GAP_EN
   localparam int unsigned GAP = (CS_GAP > 2 * CLK_DIV) ? CS_GAP : 2 * CLK_DIV;
`else
   localparam int unsigned GAP = 2 * CLK_DIV;
`endif

   logic              clk, rst;
   logic              cmd_valid, cmd_ready, cmd_wr;
   logic [ADDR_W-1:0] cmd_addr;
   logic [DATA_W-1:0] cmd_wdata;
   logic [STRB_W-1:0] cmd_wstrb;
   logic              rsp_valid, busy;
   logic [DATA_W-1:0] rsp_rdata;
   logic              spi_sck, spi_cs_n, spi_mosi, spi_miso;

   lb2spi_master #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STRB_W(STRB_W),
      .CLK_DIV(CLK_DIV), .CS_GAP(CS_GAP)
   ) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy),
      .spi_sck(spi_sck), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi), .spi_miso(spi_miso)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int unsigned n_pass = 0, n_total = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
   endtask

   typedef struct {
      logic [DATA_W-1:0] rdata;
      int unsigned       cyc;
   } rsp_t;

   rsp_t              exp_rsp[$];
   logic [N-1:0]      exp_frame[$];
   logic [DATA_W-1:0] slave_q[$];
   logic [DATA_W-1:0] last_rd;

   // response monitor
   rsp_t e_mon;
   always @(negedge clk) begin
      if (!rst && rsp_valid) begin
         if (exp_rsp.size() == 0) begin
            check("rsp_unexpected", 64'd1, 64'd0);
         end else begin
            e_mon = exp_rsp.pop_front();
            check("rsp_rdata", 64'(rsp_rdata), 64'(e_mon.rdata));
            check("rsp_latency", 64'(cyc - e_mon.cyc), 64'(LAT));
         end
      end
   end

   // SPI bus monitor and slave model (drives read data after the last control-bit fall)
   logic              prev_sck, prev_cs, is_rd_frame, in_data, have_prev, b2b;
   int unsigned       rises, gap_cnt;
   int                dbit;
   logic [N-1:0]      word, ef;
   logic [DATA_W-1:0] sval;

   always @(negedge clk) begin
      if (rst) begin
         prev_sck = 1'b0; prev_cs = 1'b1; rises = 0; word = '0;
         is_rd_frame = 1'b0; in_data = 1'b0; have_prev = 1'b0; b2b = 1'b0;
         gap_cnt = 0; spi_miso = 1'b0; dbit = 0; sval = '0;
      end else begin
         if (spi_sck && !prev_sck) begin
            word = {word[N-2:0], spi_mosi};
            rises++;
            if (rises == ADDR_W + 1) is_rd_frame = ~spi_mosi;
         end
         if (!spi_sck && prev_sck) begin
            if (is_rd_frame && rises >= ADDR_W + 8 && rises < N) begin
               if (rises == ADDR_W + 8) begin
                  if (slave_q.size() == 0) begin
                     check("slave_data_queued", 64'd0, 64'd1);
                     sval = '0;
                  end else begin
                     sval = slave_q.pop_front();
                  end
                  dbit = DATA_W - 1;
               end else begin
                  dbit--;
               end
               spi_miso = sval[dbit];
               in_data  = 1'b1;
            end else begin
               in_data = 1'b0;
            end
         end
         if (!in_data) spi_miso = 1'($urandom_range(0, 1));
         if (!spi_cs_n && prev_cs) begin
            if (have_prev) begin
               if (b2b) check("cs_gap_b2b", 64'(gap_cnt), 64'(GAP));
               else     check("cs_gap_min", 64'(gap_cnt >= GAP), 64'd1);
            end
            rises = 0; word = '0; is_rd_frame = 1'b0; in_data = 1'b0;
         end
         if (spi_cs_n && !prev_cs) begin
            check("sck_rises", 64'(rises), 64'(N));
            if (exp_frame.size() == 0) begin
               check("frame_unexpected", 64'd1, 64'd0);
            end else begin
               ef = exp_frame.pop_front();
               check("mosi_frame", 64'(word), 64'(ef));
            end
            have_prev = 1'b1; gap_cnt = 0; b2b = cmd_valid;
         end
         if (spi_cs_n) gap_cnt++;
         prev_sck = spi_sck;
         prev_cs  = spi_cs_n;
      end
   end

   // Presents a command at a negedge and waits for acceptance; leaves cmd_valid high.
   task automatic issue(input logic wr, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                        input logic [STRB_W-1:0] s, input logic [DATA_W-1:0] mv);
      int unsigned  k;
      rsp_t         e;
      logic [N-1:0] f;
      logic [7:0]   ctrl;
      cmd_wr = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s; cmd_valid = 1'b1;
      k = 0;
      while (!cmd_ready && k < 4000) begin
         @(negedge clk);
         k++;
      end
      if (!cmd_ready) begin
         check("cmd_accept_timeout", 64'd0, 64'd1);
         cmd_valid = 1'b0;
         return;
      end
      ctrl = wr ? (8'h80 | 8'(s)) : 8'h00;
      f = (N'(a) << (8 + DATA_W)) | (N'(ctrl) << DATA_W) | N'(wr ? d : '0);
      if (!wr) last_rd = mv;
      e.rdata = last_rd;
      e.cyc   = cyc;
      exp_rsp.push_back(e);
      exp_frame.push_back(f);
      if (!wr) slave_q.push_back(mv);
      @(negedge clk);
   endtask

   task automatic idle(input int unsigned n);
      cmd_valid = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   task automatic drain();
      int unsigned k = 0;
      cmd_valid = 1'b0;
      while ((exp_rsp.size() != 0 || exp_frame.size() != 0) && k < 5000) begin
         @(negedge clk);
         k++;
      end
      check("drain_pending", 64'(exp_rsp.size() + exp_frame.size()), 64'd0);
   endtask

   initial begin
      #(10 * 200000);
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned k;
      rst = 1'b1; cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
      last_rd = '0;
      repeat (3) @(negedge clk);
      check("rst_sck", 64'(spi_sck), 64'd0);
      check("rst_cs_n", 64'(spi_cs_n), 64'd1);
      check("rst_mosi", 64'(spi_mosi), 64'd0);
      check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
      check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      check("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      rst = 1'b0;
      @(negedge clk);

      issue(1'b1, 8'h5A, 8'hC3, 1'b1, 8'h00);
      idle(3);
      issue(1'b0, 8'h10, 8'hFF, 1'b1, 8'hA5);
      idle(3);
      // three commands queued with cmd_valid held high
      issue(1'b1, 8'h07, 8'h3C, 1'b1, 8'h00);
      issue(1'b0, 8'h07, 8'h00, 1'b0, 8'h3C);
      issue(1'b0, 8'hFF, 8'h00, 1'b1, 8'h01);
      idle(1);

      for (int i = 0; i < 16; i++) begin
         issue(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom),
               1'($urandom_range(0, 1)), 8'($urandom));
         if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 40));
      end
      drain();

      // reset in the middle of a write frame
      issue(1'b1, 8'($urandom), 8'($urandom), 1'b1, 8'h00);
      cmd_valid = 1'b0;
      k = 0;
      while (rises < 10 && k < 2000) begin
         @(negedge clk);
         k++;
      end
      check("reached_bit10", 64'(rises >= 10), 64'd1);
      rst = 1'b1;
      #1;
      check("abort_cs_n", 64'(spi_cs_n), 64'd1);
      check("abort_sck", 64'(spi_sck), 64'd0);
      check("abort_rsp_valid", 64'(rsp_valid), 64'd0);
      exp_rsp.delete(); exp_frame.delete(); slave_q.delete();
      last_rd = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("post_abort_ready", 64'(cmd_ready), 64'd1);
      check("post_abort_rdata", 64'(rsp_rdata), 64'd0);
      issue(1'b1, 8'h33, 8'h5E, 1'b1, 8'h00);
      issue(1'b0, 8'h44, 8'h00, 1'b0, 8'h96);
      drain();
      idle(GAP + 4);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
